// File: rtl/de2_115_sopc_pio_pkg.sv
// Shared constants and helpers for the SOPC input PIO: word address map,
// edge-select encodings and a constant-foldable ceil(log2).
package de2_115_sopc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Smallest r with 2**r >= v; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/de2_115_sopc_pio_debounce.sv
// One input bit: two-flop synchroniser, saturating debounce counter and a
// delayed copy of the debounced level for edge detection.
module de2_115_sopc_pio_debounce
    import de2_115_sopc_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 500000,
    parameter int unsigned EDGE_TYPE    = EDGE_FALL,
    parameter logic        RESET_VAL    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic cur_o,
    output logic edge_c
);

    logic sync1_q, sync2_q;
    logic deb_q, deb_d;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            deb_q   <= RESET_VAL;
            prev_q  <= RESET_VAL;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
        end
    end

    generate
        if (DEBOUNCE_CNT == 0) begin : g_bypass
            assign deb_d = sync2_q;
        end else begin : g_count
            localparam int unsigned CW = clog2(DEBOUNCE_CNT + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Count consecutive mismatching cycles; accept the new level on the last one.
            always_comb begin
                cnt_d = '0;
                deb_d = deb_q;
                if (sync2_q != deb_q) begin
                    if (cnt_q >= CNT_LAST) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        edge_c = 1'b0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_c = ~prev_q & deb_q;
            EDGE_FALL: edge_c = prev_q & ~deb_q;
            default:   edge_c = prev_q ^ deb_q;
        endcase
    end

    assign cur_o = deb_q;

endmodule

// File: rtl/de2_115_sopc_key_pio.sv
// Avalon-MM input PIO for keys/switches: debounced data, sticky edge capture
// with write-one-to-clear, and a masked level interrupt.
module de2_115_sopc_key_pio
    import de2_115_sopc_pio_pkg::*;
#(
    parameter int unsigned       WIDTH        = 4,
    parameter int unsigned       DEBOUNCE_CNT = 500000,
    parameter int unsigned       EDGE_TYPE    = EDGE_FALL,
    parameter logic [WIDTH-1:0]  IN_RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             irq_q;
    logic             wr;
    logic             unused_wd;

    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            de2_115_sopc_pio_debounce #(
                .DEBOUNCE_CNT (DEBOUNCE_CNT),
                .EDGE_TYPE    (EDGE_TYPE),
                .RESET_VAL    (IN_RESET_VAL[i])
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .in_i    (in_port[i]),
                .cur_o   (deb[i]),
                .edge_c  (edges[i])
            );
        end
    endgenerate

    assign wr        = chipselect & ~write_n;
    assign unused_wd = ^writedata;

    // A new edge is OR-ed in after the clear so a coincident event survives.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr && (address == ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edges;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            irq_q     <= |(edgecap_q & irqmask_q);
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata = 32'(deb);
                ADDR_IRQMASK: readdata = 32'(irqmask_q);
                ADDR_EDGECAP: readdata = 32'(edgecap_q);
                default:      readdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_de2_115_sopc_key_pio.sv
// Bench for the key PIO: directed register-map scenarios plus randomized
// inputs and bus traffic checked every cycle against a window-based model.
module tb_de2_115_sopc_key_pio;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned DEB       = 4;
    localparam int unsigned EDGE_TYPE = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    always #5 clk = ~clk;

    de2_115_sopc_key_pio #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_CNT (DEB),
        .EDGE_TYPE    (EDGE_TYPE),
        .IN_RESET_VAL ('1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Model: input history (newest first), accepted level, its previous value,
    // mask, capture and irq. A level is accepted once the DEB samples that
    // have passed the 2-stage synchroniser all disagree with the current level.
    logic [WIDTH-1:0] xh [DEB+2];
    logic [WIDTH-1:0] m_deb, m_prev, m_mask, m_ecap;
    logic             m_irq;

    task automatic model_reset();
        for (int j = 0; j < int'(DEB + 2); j++) xh[j] = '1;
        m_deb  = '1;
        m_prev = '1;
        m_mask = '0;
        m_ecap = '0;
        m_irq  = 1'b0;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] ev, clr, nd;
        logic             all_diff;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (EDGE_TYPE)
            0:       ev = ~m_prev & m_deb;
            1:       ev = m_prev & ~m_deb;
            default: ev = m_prev ^ m_deb;
        endcase
        for (int j = int'(DEB) + 1; j > 0; j--) xh[j] = xh[j-1];
        xh[0] = in_port;
        nd = m_deb;
        for (int b = 0; b < int'(WIDTH); b++) begin
            all_diff = 1'b1;
            for (int j = 2; j < int'(DEB) + 2; j++)
                if (xh[j][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
        end
        clr   = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        m_irq = |(m_ecap & m_mask);
        m_ecap = (m_ecap & ~clr) | ev;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
        m_prev = m_deb;
        m_deb  = nd;
    endtask

    function automatic logic [31:0] exp_read();
        if (!chipselect) return 32'h0;
        case (address)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_ecap);
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("irq_model", 32'(irq), 32'(m_irq));
        check("rd_model", readdata, exp_read());
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cycle();
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        v = readdata;
    endtask

    initial begin
        logic [31:0] v;
        int          hold;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        in_port    = '1;
        model_reset();
        run(2);
        reset_n = 1'b1;
        check("reset_irq", 32'(irq), 32'h0);
        bus_rd(2'd0, v); check("reset_data", v, 32'hF);
        bus_rd(2'd3, v); check("reset_ecap", v, 32'h0);
        bus_rd(2'd2, v); check("reset_mask", v, 32'h0);

        // Three-cycle glitch is rejected.
        in_port = 4'hE; run(3);
        in_port = 4'hF; run(8);
        bus_rd(2'd0, v); check("glitch_data", v, 32'hF);
        bus_rd(2'd3, v); check("glitch_ecap", v, 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        // Held falling edge: data after 2+4 cycles, capture +1, irq +1.
        bus_wr(2'd2, 32'h1);
        in_port = 4'hE; run(5);
        bus_rd(2'd0, v); check("fall_data_early", v, 32'hF);
        cycle();
        bus_rd(2'd0, v); check("fall_data_6", v, 32'hE);
        bus_rd(2'd3, v); check("fall_ecap_early", v, 32'h0);
        cycle();
        bus_rd(2'd3, v); check("fall_ecap", v, 32'h1);
        check("fall_irq_early", 32'(irq), 32'h0);
        cycle();
        check("fall_irq", 32'(irq), 32'h1);

        // Write-one-to-clear, then write-zero leaves bits alone.
        bus_wr(2'd3, 32'h1);
        bus_rd(2'd3, v); check("clr_ecap", v, 32'h0);
        check("clr_irq_lag", 32'(irq), 32'h1);
        cycle();
        check("clr_irq", 32'(irq), 32'h0);
        in_port = 4'hF; run(10);
        in_port = 4'hC; run(8);
        bus_rd(2'd3, v); check("ecap_3", v, 32'h3);
        bus_wr(2'd3, 32'h0);
        bus_rd(2'd3, v); check("wr0_keep", v, 32'h3);

        // Edge on bit 1 coincident with clearing bit 1: the set wins.
        in_port = 4'hE; run(10);
        in_port = 4'hC; run(6);
        bus_wr(2'd3, 32'h2);
        bus_rd(2'd3, v); check("set_wins", v, 32'h3);
        bus_wr(2'd3, 32'h2);
        bus_rd(2'd3, v); check("clr_bit1", v, 32'h1);

        // Mask gating and register reads.
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd2, 32'h0);
        in_port = 4'h8; run(8);
        bus_rd(2'd3, v); check("ecap_4", v, 32'h4);
        check("masked_irq", 32'(irq), 32'h0);
        bus_wr(2'd2, 32'h4);
        check("mask_irq_lag", 32'(irq), 32'h0);
        cycle();
        check("mask_irq", 32'(irq), 32'h1);
        bus_rd(2'd2, v); check("rd_mask", v, 32'h4);
        bus_rd(2'd1, v); check("rd_dir", v, 32'h0);
        chipselect = 1'b0; address = 2'd2; #1;
        check("rd_nocs", readdata, 32'h0);
        bus_wr(2'd0, 32'h0);
        bus_rd(2'd0, v); check("data_ro", v, 32'h8);

        // Reset while a debounce count is running.
        in_port = 4'hF; run(3);
        reset_n = 1'b0; cycle();
        reset_n = 1'b1;
        check("rst_irq", 32'(irq), 32'h0);
        bus_rd(2'd0, v); check("rst_data", v, 32'hF);
        bus_rd(2'd2, v); check("rst_mask", v, 32'h0);
        bus_rd(2'd3, v); check("rst_ecap", v, 32'h0);
        run(10);
        bus_rd(2'd3, v); check("rst_no_edge", v, 32'h0);
        bus_rd(2'd0, v); check("rst_data_hold", v, 32'hF);

        // Randomized inputs and bus traffic against the model.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                in_port = WIDTH'($urandom);
                hold    = int'($urandom_range(1, 7));
            end
            hold--;
            reset_n    = ($urandom_range(0, 299) != 0);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 9) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
